// File: rtl/operand_entry_pkg.sv
// Shared key codes, FSM state encoding and helpers for the keypad operand entry block.
package operand_entry_pkg;

    localparam logic [3:0] KEY_SIGN  = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hD;

    typedef enum logic [1:0] {
        ST_ENTRY  = 2'd0,
        ST_COMMIT = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    typedef struct packed {
        logic digit;
        logic sign;
        logic bksp;
        logic clr;
        logic enter;
    } key_dec_t;

    function automatic key_dec_t decode_key(input logic [3:0] k);
        key_dec_t d;
        d       = '0;
        d.digit = (k <= 4'd9);
        d.sign  = (k == KEY_SIGN);
        d.bksp  = (k == KEY_BKSP);
        d.clr   = (k == KEY_CLEAR);
        d.enter = (k == KEY_ENTER);
        return d;
    endfunction

    // Largest magnitude representable in a width-bit two's-complement operand.
    function automatic logic [19:0] max_mag(input int unsigned width, input logic neg);
        logic [19:0] half;
        half = 20'd1 << (width - 1);
        return neg ? half : half - 20'd1;
    endfunction

endpackage

// File: rtl/operand_entry_key_edge_detect.sv
// Turns the debounced key level into a one-cycle press pulse.
module key_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic prev;
    logic armed;

    // armed stays low until the key is seen released, so a key held through reset is not a press
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= level;
            armed <= armed | ~level;
        end
    end

    assign pulse = level & ~prev & armed;

endmodule

// File: rtl/operand_entry.sv
// Keypad operand entry: collects signed decimal operands and presents them as a held set.
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NUM_OPS    = 2,
    parameter int MAX_DIGITS = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 key_value,
    input  logic                       key_pressed,
    input  logic                       ops_ack,
    output logic [NUM_OPS*WIDTH-1:0]   operands,
    output logic                       ops_valid,
    output logic [$clog2(NUM_OPS):0]   op_index,
    output logic [WIDTH-1:0]           temp_value,
    output logic                       entry_err
);

    localparam int EXT = WIDTH + 4;
    localparam int IW  = $clog2(NUM_OPS) + 1;
    localparam int CW  = $clog2(MAX_DIGITS + 1);

    state_t                          state, state_nxt;
    logic                            key_evt;
    key_dec_t                        kd;
    logic [WIDTH-1:0]                mag;
    logic [CW-1:0]                   cnt;
    logic                            sign;
    logic [NUM_OPS-1:0][WIDTH-1:0]   ops_q;
    logic [WIDTH-1:0]                signed_val;
    logic [EXT-1:0]                  mag_nxt;
    logic [EXT-1:0]                  lim;
    logic                            dig_ok;
    logic                            sign_ok;
    logic                            last_op;

    key_edge_detect u_edge (
        .clk   (clk),
        .rst   (rst),
        .level (key_pressed),
        .pulse (key_evt)
    );

    assign kd         = decode_key(key_value);
    assign signed_val = sign ? (WIDTH'(0) - mag) : mag;
    assign last_op    = (op_index == IW'(NUM_OPS - 1));
    assign operands   = ops_q;

    // Limit depends on the current sign: negative operands reach one step further.
    always_comb begin
        mag_nxt = EXT'(mag) * EXT'(10) + EXT'(key_value);
        lim     = EXT'(max_mag(WIDTH, sign));
        dig_ok  = (cnt != CW'(MAX_DIGITS)) && (mag_nxt <= lim);
        sign_ok = !(sign && (EXT'(mag) == lim));
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_ENTRY;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ENTRY:  if (key_evt && kd.enter) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = last_op ? ST_HOLD : ST_ENTRY;
            ST_HOLD: begin
                if (ops_ack)                 state_nxt = ST_ENTRY;
                else if (key_evt && kd.clr)  state_nxt = ST_ENTRY;
            end
            default:   state_nxt = ST_ENTRY;
        endcase
    end

    always_comb begin
        ops_valid  = 1'b0;
        temp_value = signed_val;
        if (state == ST_HOLD) begin
            ops_valid  = 1'b1;
            temp_value = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mag       <= '0;
            cnt       <= '0;
            sign      <= 1'b0;
            entry_err <= 1'b0;
            ops_q     <= '0;
            op_index  <= '0;
        end else begin
            case (state)
                ST_ENTRY: if (key_evt) begin
                    if (kd.digit) begin
                        if (dig_ok) begin
                            mag       <= mag_nxt[WIDTH-1:0];
                            cnt       <= cnt + CW'(1);
                            entry_err <= 1'b0;
                        end else begin
                            entry_err <= 1'b1;
                        end
                    end else if (kd.sign) begin
                        if (sign_ok) begin
                            sign      <= ~sign;
                            entry_err <= 1'b0;
                        end else begin
                            entry_err <= 1'b1;
                        end
                    end else if (kd.bksp) begin
                        if (cnt != '0) begin
                            mag <= mag / WIDTH'(10);
                            cnt <= cnt - CW'(1);
                        end
                        entry_err <= 1'b0;
                    end else if (kd.clr) begin
                        mag       <= '0;
                        cnt       <= '0;
                        sign      <= 1'b0;
                        entry_err <= 1'b0;
                    end else if (kd.enter) begin
                        entry_err <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    for (int i = 0; i < NUM_OPS; i++)
                        if (op_index == IW'(i)) ops_q[i] <= signed_val;
                    mag       <= '0;
                    cnt       <= '0;
                    sign      <= 1'b0;
                    entry_err <= 1'b0;
                    op_index  <= op_index + IW'(1);
                end
                ST_HOLD: begin
                    // ack takes priority; a key arriving with it is dropped
                    if (ops_ack) begin
                        op_index <= '0;
                    end else if (key_evt && kd.clr) begin
                        ops_q    <= '0;
                        op_index <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with a scoreboard of expected output snapshots.
module tb_operand_entry;

    logic        clk;
    logic        rst;
    logic [3:0]  key_value;
    logic        key_pressed;
    logic        ops_ack;

    logic [15:0] operands_a;
    logic        ops_valid_a;
    logic [1:0]  op_index_a;
    logic [7:0]  temp_a;
    logic        err_a;

    logic [15:0] operands_b;
    logic        ops_valid_b;
    logic [1:0]  op_index_b;
    logic [7:0]  temp_b;
    logic        err_b;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    typedef struct {
        string       tag;
        bit          on_b;
        logic [15:0] ops;
        logic        vld;
        logic [1:0]  idx;
        logic [7:0]  temp;
        logic        err;
    } exp_t;

    exp_t sb[$];

    operand_entry #(.WIDTH(8), .NUM_OPS(2), .MAX_DIGITS(3)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .key_value   (key_value),
        .key_pressed (key_pressed),
        .ops_ack     (ops_ack),
        .operands    (operands_a),
        .ops_valid   (ops_valid_a),
        .op_index    (op_index_a),
        .temp_value  (temp_a),
        .entry_err   (err_a)
    );

    operand_entry #(.WIDTH(8), .NUM_OPS(2), .MAX_DIGITS(2)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .key_value   (key_value),
        .key_pressed (key_pressed),
        .ops_ack     (ops_ack),
        .operands    (operands_b),
        .ops_valid   (ops_valid_b),
        .op_index    (op_index_b),
        .temp_value  (temp_b),
        .entry_err   (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input bit on_b, input logic [15:0] ops,
                        input logic vld, input logic [1:0] idx, input logic [7:0] temp,
                        input logic err);
        exp_t e;
        e.tag = tag; e.on_b = on_b; e.ops = ops; e.vld = vld;
        e.idx = idx; e.temp = temp; e.err = err;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            fails++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            if (!e.on_b) begin
                chk({e.tag, ".ops"},  operands_a,          e.ops);
                chk({e.tag, ".vld"},  16'(ops_valid_a),    16'(e.vld));
                chk({e.tag, ".idx"},  16'(op_index_a),     16'(e.idx));
                chk({e.tag, ".temp"}, 16'(temp_a),         16'(e.temp));
                chk({e.tag, ".err"},  16'(err_a),          16'(e.err));
            end else begin
                chk({e.tag, ".ops"},  operands_b,          e.ops);
                chk({e.tag, ".vld"},  16'(ops_valid_b),    16'(e.vld));
                chk({e.tag, ".idx"},  16'(op_index_b),     16'(e.idx));
                chk({e.tag, ".temp"}, 16'(temp_b),         16'(e.temp));
                chk({e.tag, ".err"},  16'(err_b),          16'(e.err));
            end
        end
    endtask

    // One press: level high for one cycle, then low for one cycle; caller sits at a negedge.
    task automatic press(input logic [3:0] k);
        key_value   = k;
        key_pressed = 1'b1;
        @(negedge clk);
        key_pressed = 1'b0;
        @(negedge clk);
    endtask

    task automatic step(input logic [3:0] k, input string tag, input bit on_b,
                        input logic [15:0] ops, input logic vld, input logic [1:0] idx,
                        input logic [7:0] temp, input logic err);
        push(tag, on_b, ops, vld, idx, temp, err);
        press(k);
        check_out();
    endtask

    initial begin
        rst = 1'b0; key_value = 4'h0; key_pressed = 1'b0; ops_ack = 1'b0;
        repeat (2) @(negedge clk);
        push("reset", 0, 16'h0000, 0, 2'd0, 8'h00, 0);
        check_out();
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // two operands, commit, hold, ack
        step(4'h1, "d1",    0, 16'h0000, 0, 2'd0, 8'h01, 0);
        step(4'h2, "d12",   0, 16'h0000, 0, 2'd0, 8'h0C, 0);
        step(4'h7, "d127",  0, 16'h0000, 0, 2'd0, 8'h7F, 0);
        step(4'hD, "ent0",  0, 16'h007F, 0, 2'd1, 8'h00, 0);
        step(4'h4, "d4",    0, 16'h007F, 0, 2'd1, 8'h04, 0);
        step(4'h2, "d42",   0, 16'h007F, 0, 2'd1, 8'h2A, 0);
        step(4'hD, "ent1",  0, 16'h2A7F, 1, 2'd2, 8'h00, 0);
        step(4'h5, "hold_key", 0, 16'h2A7F, 1, 2'd2, 8'h00, 0);
        push("ack", 0, 16'h2A7F, 0, 2'd0, 8'h00, 0);
        ops_ack = 1'b1;
        @(negedge clk);
        ops_ack = 1'b0;
        check_out();

        // magnitude and sign limits
        step(4'h1, "m1",       0, 16'h2A7F, 0, 2'd0, 8'h01, 0);
        step(4'h2, "m12",      0, 16'h2A7F, 0, 2'd0, 8'h0C, 0);
        step(4'h8, "rej_mag",  0, 16'h2A7F, 0, 2'd0, 8'h0C, 1);
        step(4'hA, "neg12",    0, 16'h2A7F, 0, 2'd0, 8'hF4, 0);
        step(4'h8, "neg128",   0, 16'h2A7F, 0, 2'd0, 8'h80, 0);
        step(4'hA, "rej_sign", 0, 16'h2A7F, 0, 2'd0, 8'h80, 1);
        step(4'hC, "clr",      0, 16'h2A7F, 0, 2'd0, 8'h00, 0);

        // empty commit, negative commit, clear in hold
        step(4'hD, "ent_zero", 0, 16'h2A00, 0, 2'd1, 8'h00, 0);
        step(4'hA, "negzero",  0, 16'h2A00, 0, 2'd1, 8'h00, 0);
        step(4'h5, "neg5",     0, 16'h2A00, 0, 2'd1, 8'hFB, 0);
        step(4'hD, "ent_neg5", 0, 16'hFB00, 1, 2'd2, 8'h00, 0);
        step(4'hC, "hold_clr", 0, 16'h0000, 0, 2'd0, 8'h00, 0);

        // backspace keeps the sign; digit count cap; ignored codes
        step(4'hA, "s_neg",    0, 16'h0000, 0, 2'd0, 8'h00, 0);
        step(4'h3, "neg3",     0, 16'h0000, 0, 2'd0, 8'hFD, 0);
        step(4'hB, "bs_neg",   0, 16'h0000, 0, 2'd0, 8'h00, 0);
        step(4'h2, "sign_kept",0, 16'h0000, 0, 2'd0, 8'hFE, 0);
        step(4'hD, "ent_m2",   0, 16'h00FE, 0, 2'd1, 8'h00, 0);
        step(4'h1, "c1",       0, 16'h00FE, 0, 2'd1, 8'h01, 0);
        step(4'h2, "c12",      0, 16'h00FE, 0, 2'd1, 8'h0C, 0);
        step(4'h3, "c123",     0, 16'h00FE, 0, 2'd1, 8'h7B, 0);
        step(4'h4, "rej_cnt",  0, 16'h00FE, 0, 2'd1, 8'h7B, 1);
        step(4'hE, "ignored",  0, 16'h00FE, 0, 2'd1, 8'h7B, 1);
        step(4'hB, "bs12",     0, 16'h00FE, 0, 2'd1, 8'h0C, 0);
        step(4'hD, "ent12",    0, 16'h0CFE, 1, 2'd2, 8'h00, 0);

        // ack and key in the same hold cycle
        push("ack_key", 0, 16'h0CFE, 0, 2'd0, 8'h00, 0);
        ops_ack = 1'b1; key_value = 4'h3; key_pressed = 1'b1;
        @(negedge clk);
        ops_ack = 1'b0; key_pressed = 1'b0;
        check_out();
        @(negedge clk);

        // reset in the middle of entering -45
        step(4'h4, "e4",    0, 16'h0CFE, 0, 2'd0, 8'h04, 0);
        step(4'h5, "e45",   0, 16'h0CFE, 0, 2'd0, 8'h2D, 0);
        step(4'hA, "em45",  0, 16'h0CFE, 0, 2'd0, 8'hD3, 0);
        push("rst_mid", 0, 16'h0000, 0, 2'd0, 8'h00, 0);
        rst = 1'b0;
        @(negedge clk);
        check_out();
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // long hold is a single press
        push("held20", 0, 16'h0000, 0, 2'd0, 8'h05, 0);
        key_value = 4'h5; key_pressed = 1'b1;
        repeat (20) @(negedge clk);
        key_pressed = 1'b0;
        @(negedge clk);
        check_out();
        step(4'hC, "clr2", 0, 16'h0000, 0, 2'd0, 8'h00, 0);

        // key held through reset release makes no event
        key_value = 4'h7; key_pressed = 1'b1; rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        push("held_rst", 0, 16'h0000, 0, 2'd0, 8'h00, 0);
        check_out();
        key_pressed = 1'b0;
        repeat (2) @(negedge clk);
        step(4'h6, "after_rel", 0, 16'h0000, 0, 2'd0, 8'h06, 0);

        // two-digit limit instance
        step(4'hC, "b_clr",  1, 16'h0000, 0, 2'd0, 8'h00, 0);
        step(4'h9, "b9",     1, 16'h0000, 0, 2'd0, 8'h09, 0);
        step(4'h9, "b99",    1, 16'h0000, 0, 2'd0, 8'h63, 0);
        step(4'h9, "b_rej",  1, 16'h0000, 0, 2'd0, 8'h63, 1);
        step(4'hB, "b_bs9",  1, 16'h0000, 0, 2'd0, 8'h09, 0);
        step(4'hB, "b_bs0",  1, 16'h0000, 0, 2'd0, 8'h00, 0);
        step(4'hB, "b_bsnop",1, 16'h0000, 0, 2'd0, 8'h00, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (two's complement), legal range 4..16.
REQ-002 SHALL have parameter NUM_OPS, default 2, number of operands captured per entry cycle, range 1..4.
REQ-003 SHALL have parameter MAX_DIGITS, default 3, maximum decimal digits accepted per operand.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port key_value  input  4  key code: 0-9 digit, 4'hA sign toggle, 4'hB backspace, 4'hC clear, 4'hD enter; 4'hE/4'hF ignored.
REQ-007 SHALL have port key_pressed  input  1  level from keypad scanner, already debounced.
REQ-008 SHALL have port ops_ack  input  1  consumer accepts the operand set.
REQ-009 SHALL have port operands  output  NUM_OPS*WIDTH  committed operands, operand i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port ops_valid  output  1  all NUM_OPS operands committed and held.
REQ-011 SHALL have port op_index  output  $clog2(NUM_OPS)+1  index of operand being entered.
REQ-012 SHALL have port temp_value  output  WIDTH  signed value under entry, for display.
REQ-013 SHALL have port entry_err  output  1  sticky: last key rejected.

Function
REQ-014 A key event SHALL be key_pressed high while its registered previous sample is low; one event per press; state updates on the same edge, outputs visible one cycle later.
REQ-015 SHALL be a three-state FSM: ENTRY (collect digits for op_index), COMMIT (one cycle: write operand, advance index), HOLD (ops_valid=1, wait ops_ack).
REQ-016 Digit in ENTRY SHALL set magnitude = magnitude*10 + digit, computed in WIDTH+4 bits, and increment digit count.
REQ-017 Digit SHALL be rejected (state unchanged, entry_err=1) if digit count = MAX_DIGITS or new magnitude exceeds 2^(WIDTH-1)-1 (positive) or 2^(WIDTH-1) (negative).
REQ-018 Sign toggle SHALL invert the sign flag; rejected with entry_err=1 if magnitude = 2^(WIDTH-1) and sign is negative.
REQ-019 Backspace SHALL set magnitude = magnitude/10, decrement digit count; no-op at count 0; sign retained.
REQ-020 Clear SHALL zero magnitude, count, sign and entry_err of the current operand only; previously committed operands kept.
REQ-021 Enter SHALL go to COMMIT; zero digits commits 0; a negative-zero commits 0.
REQ-022 COMMIT SHALL write two's-complement value to slot op_index, clear the entry buffer and entry_err, increment op_index, go to ENTRY, or to HOLD if op_index was NUM_OPS-1.
REQ-023 temp_value SHALL equal the sign-applied magnitude in ENTRY and 0 in HOLD.
REQ-024 In HOLD all keys except clear SHALL be ignored; clear in HOLD SHALL zero all operands, op_index=0, go to ENTRY.
REQ-025 ops_ack in HOLD SHALL drop ops_valid next cycle, set op_index=0, go to ENTRY, operands retained until overwritten; ops_ack outside HOLD ignored.
REQ-026 ops_ack and a key event in the same HOLD cycle: ack SHALL win, key dropped.
REQ-027 entry_err SHALL clear on the next accepted key of any kind.

Reset
REQ-028 With rst low at a clock edge: operands=0, ops_valid=0, op_index=0, temp_value=0, entry_err=0, sign=0, count=0, state ENTRY, previous key sample=0.
REQ-029 Reset mid-entry or in HOLD SHALL discard all partial and committed data; a key held through reset release SHALL NOT generate an event.

Structure
REQ-030 Key codes, FSM state enum and a max-magnitude function SHALL live in package operand_entry_pkg.
REQ-031 Press edge detection SHALL be sub-module key_edge_detect (clk, rst, level in, pulse out).

Verification
REQ-032 Keys 1,2,7,D,4,2,D -> after second commit ops_valid=1, operands={8'd42,8'd127}; ops_ack -> ops_valid=0, op_index=0.
REQ-033 Keys 1,2,8 -> third digit rejected, temp_value=12, entry_err=1; then A,8 -> temp_value=-128; then A -> rejected, entry_err=1.
REQ-034 Keys 9,9,9 with MAX_DIGITS=2 -> temp_value=99, entry_err=1; B -> temp_value=9, entry_err=0; B,B -> 0, no error.
REQ-035 key_pressed held high 20 cycles on digit 5 -> exactly one digit accepted, temp_value=5.
REQ-036 In HOLD, ops_ack and key 3 same cycle -> ENTRY with temp_value=0; rst low during entry of -45 -> all outputs 0 next cycle.
